// File: rtl/req_ack_dst_bridge.sv
// rtl/req_ack_dst_bridge.sv - req/ack responder that reissues each request as a valid/ready cmd/rsp exchange
// Optional command/response timeout with late-response discard: REQ_ACK_DST_TIMEOUT_EN
module req_ack_dst_bridge #(
  parameter int                 DATA_W         = 32,
  parameter int                 RDATA_W        = 32,
  parameter int                 TIMEOUT_CYCLES = 256,
  parameter logic [RDATA_W-1:0] ERR_RDATA      = RDATA_W'(32'hDEAD_BEEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [DATA_W-1:0]  data,
  output logic               ack,
  output logic [RDATA_W-1:0] rdata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [DATA_W-1:0]  cmd_data,
  input  logic               rsp_valid,
  output logic               rsp_ready,
  input  logic [RDATA_W-1:0] rsp_data,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_ACK} state_t;

  state_t               r_state;
  logic                 r_ack;
  logic                 r_cmd_valid;
  logic                 r_rsp_ready;
  logic                 r_busy;
  logic                 r_timeout_err;
  logic [DATA_W-1:0]    r_cmd_data;
  logic [RDATA_W-1:0]   r_rdata;

  logic w_rsp_hs;
  logic w_rsp_take;
  logic w_tmo;
  logic w_to_rsp;
  logic w_rsp_ready_nxt;

  assign w_rsp_hs = rsp_valid & r_rsp_ready;
  assign w_to_rsp = (((r_state == S_CMD) & cmd_ready) |
                     ((r_state == S_RSP) & ~w_rsp_take)) & ~w_tmo;

`ifdef REQ_ACK_DST_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  TMO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic [3:0]       r_disc_cnt;
  logic [3:0]       w_disc_nxt;
  logic             w_discard;
  logic             w_disc_inc;

  // Any handshake taken while responses are owed from aborted transactions is swallowed.
  assign w_discard  = w_rsp_hs & (r_disc_cnt != 4'd0);
  assign w_rsp_take = (r_state == S_RSP) & w_rsp_hs & ~w_discard;
  assign w_tmo      = ((r_state == S_CMD) | (r_state == S_RSP)) & (r_tmo_cnt == TMO_MAX) &
                      ~((r_state == S_CMD) & cmd_ready) & ~w_rsp_take;
  assign w_disc_inc = w_tmo & (r_state == S_RSP);

  always_comb begin
    w_disc_nxt = r_disc_cnt;
    if (w_disc_inc & ~w_discard) begin
      if (r_disc_cnt != 4'hF) w_disc_nxt = r_disc_cnt + 4'd1;
    end else if (~w_disc_inc & w_discard) begin
      w_disc_nxt = r_disc_cnt - 4'd1;
    end
  end

  assign w_rsp_ready_nxt = w_to_rsp | (w_disc_nxt != 4'd0);

  // Holds at the threshold so a handshake that wins on the last cycle cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt  <= '0;
      r_disc_cnt <= 4'd0;
    end else begin
      r_disc_cnt <= w_disc_nxt;
      if (r_state == S_IDLE) begin
        r_tmo_cnt <= '0;
      end else if ((r_state != S_ACK) && (r_tmo_cnt != TMO_MAX)) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign w_rsp_take      = (r_state == S_RSP) & w_rsp_hs;
  assign w_tmo           = 1'b0;
  assign w_rsp_ready_nxt = w_to_rsp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ack         <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_rsp_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cmd_data    <= '0;
      r_rdata       <= '0;
    end else begin
      r_ack         <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rsp_ready   <= w_rsp_ready_nxt;
      if (w_tmo) begin
        r_state       <= S_ACK;
        r_ack         <= 1'b1;
        r_timeout_err <= 1'b1;
        r_rdata       <= ERR_RDATA;
        r_cmd_valid   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req) begin
              r_state     <= S_CMD;
              r_cmd_data  <= data;
              r_cmd_valid <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          S_CMD: begin
            if (cmd_ready) begin
              r_state     <= S_RSP;
              r_cmd_valid <= 1'b0;
            end
          end
          S_RSP: begin
            if (w_rsp_take) begin
              r_state <= S_ACK;
              r_rdata <= rsp_data;
              r_ack   <= 1'b1;
            end
          end
          S_ACK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_data    = r_cmd_data;
  assign rsp_ready   = r_rsp_ready;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_req_ack_dst_bridge.sv
// tb/tb_req_ack_dst_bridge.sv - self-checking bench for req_ack_dst_bridge
// Timeout/discard sequences are built when REQ_ACK_DST_TIMEOUT_EN is defined
module tb_req_ack_dst_bridge;
  localparam int DW  = 32;
  localparam int RW  = 32;
  localparam int TMO = 8;
`ifdef REQ_ACK_DST_TIMEOUT_EN
  localparam int BP_C = 3;
  localparam int BP_R = 2;
`else
  localparam int BP_C = 5;
  localparam int BP_R = 3;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    int            cdly;
    int            rdly;
    bit            b2b;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [DW-1:0] data = '0;
  logic          cmd_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [RW-1:0] rsp_data = '0;
  logic          ack, cmd_valid, rsp_ready, busy, timeout_err;
  logic [DW-1:0] cmd_data;
  logic [RW-1:0] rdata;

  int            n_run = 0;
  int            n_fail = 0;
  logic [RW-1:0] last_rdata = '0;
  logic [DW-1:0] cmd_q[$];
  logic [RW-1:0] rsp_q[$];

  always #5 clk = ~clk;

  req_ack_dst_bridge #(
    .DATA_W(DW), .RDATA_W(RW), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack), .rdata(rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one src transaction against a target model with the given ready/valid delays.
  task automatic run_txn(input logic [DW-1:0] d, input logic [RW-1:0] r,
                         input int cdly, input int rdly, input bit b2b);
    int cyc = 0, cw = 0, rw = 0, extra = 0, busy_bad = 0, unstable = 0;
    bit cmd_done = 0, rsp_sent = 0, done = 0;
    logic [DW-1:0] exp_cmd;
    logic [RW-1:0] exp_rsp;
    req = 1'b1;
    data = d;
    cmd_q.push_back(d);
    rsp_q.push_back(r);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      if (cyc >= (b2b ? 2 : 1) && !busy) busy_bad++;
      if (cmd_valid) begin
        data = ~d;
        if (cmd_done) extra++;
        else begin
          if (cmd_data !== cmd_q[0]) unstable++;
          cw++;
          if (cw == cdly + 1) begin
            exp_cmd = cmd_q.pop_front();
            check("cmd_data", cmd_data, exp_cmd);
            cmd_ready = 1'b1;
            cmd_done = 1;
          end
        end
      end
      if (rsp_ready && cmd_done && !rsp_sent) begin
        rw++;
        if (rw == rdly + 1) begin
          rsp_valid = 1'b1;
          rsp_data = r;
          rsp_sent = 1;
        end
      end
      if (ack) begin
        exp_rsp = rsp_q.pop_front();
        check("ack_rdata", rdata, exp_rsp);
        check("ack_timeout_err", timeout_err, 1'b0);
        check("ack_latency", cyc, 3 + cdly + rdly + (b2b ? 1 : 0));
        check("busy_during_txn", busy_bad, 0);
        check("extra_cmd_cycles", extra, 0);
        check("cmd_data_stable", unstable, 0);
        last_rdata = exp_rsp;
        req = 1'b0;
        done = 1;
      end
    end
    if (!done) check("ack_seen", 0, 1);
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   cyc;
    vecs[0] = '{d: 32'h0000_1234, r: 32'h0000_ABCD, cdly: 0,    rdly: 0,    b2b: 0};
    vecs[1] = '{d: 32'hCAFE_0001, r: 32'h5A5A_0001, cdly: BP_C, rdly: BP_R, b2b: 0};
    vecs[2] = '{d: 32'h0000_0001, r: 32'h1000_1001, cdly: 0,    rdly: 0,    b2b: 0};
    vecs[3] = '{d: 32'h0000_0002, r: 32'h2000_2002, cdly: 0,    rdly: 0,    b2b: 1};
    vecs[4] = '{d: 32'h0000_0003, r: 32'h3000_3003, cdly: 0,    rdly: 0,    b2b: 1};
    vecs[5] = '{d: 32'hFFFF_FFFF, r: 32'h0000_0000, cdly: 2,    rdly: 1,    b2b: 0};

    repeat (2) @(negedge clk);
    check("reset_ctrl", {ack, cmd_valid, rsp_ready, busy, timeout_err}, 5'b0);
    check("reset_cmd_data", cmd_data, 0);
    check("reset_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b) begin
        @(negedge clk);
        check("idle_gap", {ack, busy}, 2'b00);
      end
      run_txn(vecs[i].d, vecs[i].r, vecs[i].cdly, vecs[i].rdly, vecs[i].b2b);
    end
    @(negedge clk);
    check("final_ack_drop", {ack, busy}, 2'b00);

    // Stray responses in IDLE must be refused and leave rdata untouched.
    rsp_valid = 1'b1;
    rsp_data = 32'h5A5A_5A5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_rsp_ready", rsp_ready, 1'b0);
      check("stray_busy", busy, 1'b0);
      check("stray_rdata", rdata, last_rdata);
    end
    rsp_valid = 1'b0;

    // Asynchronous reset while waiting for a response.
    req = 1'b1;
    data = 32'h0000_0BAD;
    for (int k = 0; k < 20 && !rsp_ready; k++) begin
      @(negedge clk);
      cmd_ready = cmd_valid;
    end
    cmd_ready = 1'b0;
    check("reach_rsp", rsp_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {ack, cmd_valid, rsp_ready, busy, timeout_err}, 5'b0);
    check("async_rst_data", {cmd_data, rdata}, 64'h0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_ack", {ack, busy}, 2'b00);
    end
    last_rdata = '0;
    run_txn(32'h0000_4321, 32'h0000_8765, 1, 1, 0);

`ifdef REQ_ACK_DST_TIMEOUT_EN
    // Response timeout: command accepted, target never answers.
    @(negedge clk);
    req = 1'b1;
    data = 32'h0000_0077;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      cmd_ready = cmd_valid;
      if (ack) break;
    end
    cmd_ready = 1'b0;
    check("tmo_rsp_latency", cyc, TMO + 1);
    check("tmo_rsp_rdata", rdata, 32'hDEAD_BEEF);
    check("tmo_rsp_err", timeout_err, 1'b1);
    req = 1'b0;
    @(negedge clk);
    check("discard_ready_idle", rsp_ready, 1'b1);
    check("tmo_err_pulse", {ack, timeout_err}, 2'b00);
    rsp_valid = 1'b1;
    rsp_data = 32'h0000_0055;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("discard_done", rsp_ready, 1'b0);
    check("discard_rdata", rdata, 32'hDEAD_BEEF);
    last_rdata = 32'hDEAD_BEEF;
    run_txn(32'h0000_0088, 32'h0000_0066, 0, 0, 0);

    // Command timeout: target never accepts, no discard owed.
    @(negedge clk);
    req = 1'b1;
    data = 32'h0000_0099;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ack) break;
    end
    check("tmo_cmd_latency", cyc, TMO + 1);
    check("tmo_cmd_err", timeout_err, 1'b1);
    check("tmo_cmd_valid_drop", cmd_valid, 1'b0);
    check("tmo_cmd_rdata", rdata, 32'hDEAD_BEEF);
    req = 1'b0;
    @(negedge clk);
    check("tmo_cmd_no_discard", rsp_ready, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/req_ack_dst_bridge.md
Name: req_ack_dst_bridge

Overview:
Destination (responder) end of the blocking req/ack protocol. Accepts one src transaction (req + data) and reissues it as a valid/ready command to a downstream target. It then waits for the target's valid/ready response and returns that response to the src as a one-cycle ack with rdata. Sits between any req/ack source and a streaming target such as a register bank or memory controller.

Parameters:
DATA_W, 32, width of src data and cmd_data
RDATA_W, 32, width of rdata and rsp_data
TIMEOUT_CYCLES, 256, cycles allowed from command issue to response (feature only); must be >=2
ERR_RDATA, 'hDEAD_BEEF, rdata returned on timeout (feature only), truncated to RDATA_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  1  src request, held high until ack
data  in  DATA_W  src request payload, valid while req high
ack  out  1  one-cycle completion pulse to src
rdata  out  RDATA_W  response payload, valid in ack cycle, held afterwards
cmd_valid  out  1  downstream command valid
cmd_ready  in  1  downstream command ready
cmd_data  out  DATA_W  downstream command payload
rsp_valid  in  1  downstream response valid
rsp_ready  out  1  downstream response ready
rsp_data  in  RDATA_W  downstream response payload
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse with ack on timeout; tied 0 when the feature is compiled out

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; ack, cmd_valid, rsp_ready, busy, timeout_err = 0; cmd_data = 0; rdata = 0.
- IDLE: if req=1, register data into cmd_data and go to CMD. Otherwise stay in IDLE.
- CMD: cmd_valid=1. cmd_data is stable until the handshake. On cmd_valid&cmd_ready, go to RSP.
- RSP: rsp_ready=1. On rsp_valid&rsp_ready, register rsp_data into rdata and go to ACK.
- ACK: ack=1 for exactly one cycle, then return to IDLE.
- Outputs are decoded from state only. There are no combinational paths from inputs to outputs.
- Minimum latency: req first high in cycle 0 gives cmd_valid in cycle 1. If cmd_ready=1 in cycle 1, the state is RSP in cycle 2. If rsp_valid=1 in cycle 2, ack is high in cycle 3.
- Src drops req on the edge that ends the ack cycle, so req is low when IDLE is next sampled. A src that raises req again immediately starts a new transaction the cycle after ACK (back-to-back throughput of 1 per 4 cycles).
- data is sampled only in IDLE. Changes while req is high after capture are ignored.
- req deasserted early (protocol violation): the transaction still completes and ack still pulses.
- rsp_valid outside RSP is not accepted (rsp_ready=0), except for discards (see feature).
- rdata holds its last value until the next response capture.
- Reset mid-operation returns to IDLE immediately. The in-flight downstream transaction is abandoned and no ack is issued.

Optional Feature:
Macro REQ_ACK_DST_TIMEOUT_EN.
With the macro defined:
- A counter clears on entering CMD and increments each cycle in CMD and RSP.
- If it reaches TIMEOUT_CYCLES-1 with no completing handshake that cycle, go to ACK with rdata=ERR_RDATA and timeout_err=1 for the ack cycle.
- Timeout in CMD: the command was never accepted, so nothing is owed downstream; cmd_valid drops (abort).
- Timeout in RSP: increment a 4-bit saturating discard counter. While the discard counter is nonzero, rsp_ready=1 in every state. The next rsp handshake is dropped and decrements the counter. In RSP state, discarded responses do not complete the current transaction.
- A handshake in the same cycle as the timeout threshold wins over the timeout.
Without the macro: no counter and no discard logic, timeout_err=0, and the bridge waits indefinitely.

Test Plan:
- Single transaction, target always ready: req=1, data=0x1234; rsp_data=0xABCD in cycle 2 -> cmd_valid cycle 1 with cmd_data=0x1234, ack=1 cycle 3 with rdata=0xABCD, busy cycles 1-3.
- Backpressure: cmd_ready low 5 cycles, rsp_valid delayed 3 cycles -> cmd_data stable throughout, exactly one cmd and one rsp handshake, ack exactly one cycle.
- Back-to-back: src reissues req immediately with data 0x1, 0x2, 0x3 -> three commands in order, acks return 0x1 response, 0x2 response, 0x3 response, 4-cycle spacing.
- Stray response: rsp_valid=1 in IDLE -> rsp_ready=0, no state change, rdata unchanged.
- Reset mid-RSP: rst_n low for 1 cycle -> all outputs 0 asynchronously, IDLE, no ack; a following transaction completes normally.
- Timeout (REQ_ACK_DST_TIMEOUT_EN, TIMEOUT_CYCLES=8): cmd accepted, no response -> ack with rdata=ERR_RDATA and timeout_err=1. A late response 0x55 is discarded. The next transaction returns its own response, not 0x55.
